// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register in-flight write counters, issue
// back-pressure, writeback retirement and RAW hazard flags for two source ports.

module regfile_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  // inc and dec together leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (inc && !dec) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc) cnt <= cnt - CNT_W'(1);
  end
endmodule

module regfile_scoreboard #(
  parameter int ADDR_W       = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter int ZERO_REG     = 31,
  parameter bit WB_BYPASS    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic                  issue_ready,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [ADDR_W+1:0]     inflight,
  output logic                  err
);
  localparam int NREGS = 2**ADDR_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
  localparam int IF_W  = ADDR_W+2;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  MAX_C  = CNT_W'(MAX_INFLIGHT);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            inc_vec, dec_vec;
  logic [CNT_W-1:0]            issue_cnt, wb_cnt, cnt_a, cnt_b;
  logic                        ready_raw, inc, dec, wb_bad;
  logic                        bypass_a, bypass_b;

  assign issue_cnt = cnt[issue_addr];
  assign wb_cnt    = cnt[wb_addr];
  assign cnt_a     = cnt[rd_addr_a];
  assign cnt_b     = cnt[rd_addr_b];

  // A same-cycle retire on a full register frees the slot the issue needs
  assign ready_raw = !issue_en || (issue_addr == ZERO_A) || (issue_cnt < MAX_C) ||
                     (wb_en && (wb_addr == issue_addr) && (issue_cnt != '0));
  assign issue_ready = reset || ready_raw;

  assign inc    = !reset && issue_en && ready_raw && (issue_addr != ZERO_A);
  assign dec    = !reset && wb_en && (wb_addr != ZERO_A) && (wb_cnt != '0);
  assign wb_bad = wb_en && (wb_addr != ZERO_A) && (wb_cnt == '0);

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : g_reg
      assign inc_vec[r] = inc && (issue_addr == ADDR_W'(r));
      assign dec_vec[r] = dec && (wb_addr == ADDR_W'(r));
      assign pending[r] = |cnt[r];

      regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec[r]),
        .dec   (dec_vec[r]),
        .cnt   (cnt[r])
      );
    end
  endgenerate

  // Retiring the last pending write hides the hazard in the writeback cycle
  assign bypass_a = WB_BYPASS && dec && (wb_addr == rd_addr_a) && (wb_cnt == CNT_W'(1));
  assign bypass_b = WB_BYPASS && dec && (wb_addr == rd_addr_b) && (wb_cnt == CNT_W'(1));

  assign busy_a = !reset && (rd_addr_a != ZERO_A) && (cnt_a != '0) && !bypass_a;
  assign busy_b = !reset && (rd_addr_b != ZERO_A) && (cnt_b != '0) && !bypass_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= inflight + IF_W'(inc) - IF_W'(dec);
      if (wb_bad) err <= 1'b1;
    end
  end
endmodule
